mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single 16x32 program/data memory behind the GPP.
- Port 0 is the GPP fetch/load port. Port 1 is the host program loader.
- Serialises accesses, drives the memory's Addr/RW/En strobe, waits a fixed read latency, then returns data with a one-cycle Ack.
- Round-robin fairness, so the loader can patch memory while the GPP runs without starving either side.

---
 rtl/gpp_mem_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/rr_select2.sv | 13 +
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpp_mem_pkg.sv
// Shared definitions for the GPP program/data memory port arbiter.
package gpp_mem_pkg;

    localparam int unsigned AW_DEF = 4;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic PORT_GPP = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master = environment, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = gpp_mem_pkg::AW_DEF,
    parameter int unsigned DW = gpp_mem_pkg::DW_DEF
);
    logic          Req0;
    logic          RW0;
    logic [AW-1:0] Addr0;
    logic [DW-1:0] WData0;
    logic          Gnt0;
    logic          Ack0;
    logic [DW-1:0] RData0;

    logic          Req1;
    logic          RW1;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] WData1;
    logic          Gnt1;
    logic          Ack1;
    logic [DW-1:0] RData1;

    logic [AW-1:0] MAddr;
    logic          MRW;
    logic          MEn;
    logic [DW-1:0] MWData;
    logic [DW-1:0] MRData;
    logic          Busy;

    modport slave (
        input  Req0, RW0, Addr0, WData0, Req1, RW1, Addr1, WData1, MRData,
        output Gnt0, Ack0, RData0, Gnt1, Ack1, RData1, MAddr, MRW, MEn, MWData, Busy
    );

    modport master (
        output Req0, RW0, Addr0, WData0, Req1, RW1, Addr1, WData1, MRData,
        input  Gnt0, Ack0, RData0, Gnt1, Ack1, RData1, MAddr, MRW, MEn, MWData, Busy
    );
endinterface

// File: rtl/rr_select2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
module rr_select2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic sel_c,
    output logic valid_c
);
    always_comb begin
        valid_c = req0 | req1;
        sel_c   = (req0 && req1) ? ~last_gnt : req1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises GPP and loader accesses onto the single memory port with fixed read latency.
module mem_port_arbiter
    import gpp_mem_pkg::*;
#(
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned LAT = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 1) ? LAT - 2 : 0);

    state_e           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    maddr_q, maddr_d;
    logic             mrw_q, mrw_d;
    logic             men_q, men_d;
    logic [DW-1:0]    mwdata_q, mwdata_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DW-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic             busy_q, busy_d;
    logic             sel_c, valid_c, capture_c;

    rr_select2 u_sel (
        .req0     (bus.Req0),
        .req1     (bus.Req1),
        .last_gnt (last_gnt_q),
        .sel_c    (sel_c),
        .valid_c  (valid_c)
    );

    // Next-state and output logic; last_gnt_q doubles as the current owner while busy.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        maddr_d    = maddr_q;
        mrw_d      = mrw_q;
        mwdata_d   = mwdata_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        men_d      = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        capture_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_c) begin
                    state_d    = ST_ACCESS;
                    last_gnt_d = sel_c;
                    men_d      = 1'b1;
                    gnt0_d     = (sel_c == PORT_GPP);
                    gnt1_d     = (sel_c == PORT_LDR);
                    maddr_d    = (sel_c == PORT_LDR) ? bus.Addr1  : bus.Addr0;
                    mrw_d      = (sel_c == PORT_LDR) ? bus.RW1    : bus.RW0;
                    mwdata_d   = (sel_c == PORT_LDR) ? bus.WData1 : bus.WData0;
                end
            end
            ST_ACCESS: begin
                if (LAT <= 1) begin
                    capture_c = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    capture_c = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Entering RESP: raise the owner's Ack and, for reads, take the memory data.
        if (capture_c) begin
            ack0_d = (last_gnt_q == PORT_GPP);
            ack1_d = (last_gnt_q == PORT_LDR);
            if (mrw_q == RW_READ) begin
                if (last_gnt_q == PORT_LDR) rdata1_d = bus.MRData;
                else                        rdata0_d = bus.MRData;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            maddr_q    <= '0;
            mrw_q      <= 1'b0;
            men_q      <= 1'b0;
            mwdata_q   <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            maddr_q    <= maddr_d;
            mrw_q      <= mrw_d;
            men_q      <= men_d;
            mwdata_q   <= mwdata_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.Gnt0   = gnt0_q;
    assign bus.Gnt1   = gnt1_q;
    assign bus.Ack0   = ack0_q;
    assign bus.Ack1   = ack1_q;
    assign bus.RData0 = rdata0_q;
    assign bus.RData1 = rdata1_q;
    assign bus.MAddr  = maddr_q;
    assign bus.MRW    = mrw_q;
    assign bus.MEn    = men_q;
    assign bus.MWData = mwdata_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised transaction-level bench for two arbiter instances (LAT=1 and LAT=3).
module tb_mem_port_arbiter;
    import gpp_mem_pkg::*;

    logic clk;
    logic rst_n;

    logic [1:0]       req0, rw0, req1, rw1;
    logic [1:0][3:0]  addr0, addr1;
    logic [1:0][31:0] wdata0, wdata1, mrdata;
    logic [1:0]       gnt0_o, gnt1_o, ack0_o, ack1_o, men_o, mrw_o, busy_o;
    logic [1:0][3:0]  maddr_o;
    logic [1:0][31:0] mwdata_o, rdata0_o, rdata1_o;

    // Reference model state
    logic [31:0] ref_mem   [2][16];
    logic [31:0] rdata_ref [2][2];
    bit          last_gnt  [2];

    // Memory device model behind each arbiter
    logic [31:0] tmem [2][16];
    logic [3:0]  mla  [2];
    int          since [2] = '{100, 100};
    bit          mem_ready = 1'b0;

    int n_checks = 0;
    int n_errs   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter_if bus ();
        assign bus.Req0   = req0[g];
        assign bus.RW0    = rw0[g];
        assign bus.Addr0  = addr0[g];
        assign bus.WData0 = wdata0[g];
        assign bus.Req1   = req1[g];
        assign bus.RW1    = rw1[g];
        assign bus.Addr1  = addr1[g];
        assign bus.WData1 = wdata1[g];
        assign bus.MRData = mrdata[g];
        assign gnt0_o[g]   = bus.Gnt0;
        assign gnt1_o[g]   = bus.Gnt1;
        assign ack0_o[g]   = bus.Ack0;
        assign ack1_o[g]   = bus.Ack1;
        assign rdata0_o[g] = bus.RData0;
        assign rdata1_o[g] = bus.RData1;
        assign maddr_o[g]  = bus.MAddr;
        assign mrw_o[g]    = bus.MRW;
        assign men_o[g]    = bus.MEn;
        assign mwdata_o[g] = bus.MWData;
        assign busy_o[g]   = bus.Busy;

        mem_port_arbiter #(.LAT(g == 0 ? 1 : 3)) u_dut (
            .Clk (clk),
            .Rst (rst_n),
            .bus (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int d, input int a);
        if (a == 3) return 32'hDEADBEEF;
        return 32'h5A5A0000 ^ 32'(a * 16 + d) ^ (32'(a) << 20);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory: data is only valid in the cycle before the LAT-th edge after the MEn edge.
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 16; a++) tmem[d][a] = init_word(d, a);
            mem_ready = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            if (men_o[d]) begin
                since[d] = 0;
                mla[d]   = maddr_o[d];
                if (mrw_o[d]) tmem[d][maddr_o[d]] = mwdata_o[d];
            end else if (since[d] < 100) begin
                since[d]++;
            end
            mrdata[d] = (since[d] == lat_of(d) - 1) ? tmem[d][mla[d]] : $urandom;
        end
    end

    // Grants and acks must never overlap between ports.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++)
            check("excl", {30'd0, gnt0_o[d] & gnt1_o[d], ack0_o[d] & ack1_o[d]}, 32'd0);
    end

    task automatic set_port(input int d, input bit p, input bit r, input bit rw,
                            input logic [3:0] a, input logic [31:0] wd);
        if (p) begin
            req1[d] = r; rw1[d] = rw; addr1[d] = a; wdata1[d] = wd;
        end else begin
            req0[d] = r; rw0[d] = rw; addr0[d] = a; wdata0[d] = wd;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_gnt[d]     = 1'b1;
            rdata_ref[d][0] = '0;
            rdata_ref[d][1] = '0;
        end
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_gnt_ack", {26'd0, gnt0_o[d], gnt1_o[d], ack0_o[d], ack1_o[d], men_o[d], mrw_o[d]}, 32'd0);
        check("rst_busy",   {31'd0, busy_o[d]}, 32'd0);
        check("rst_maddr",  {28'd0, maddr_o[d]}, 32'd0);
        check("rst_mwdata", mwdata_o[d], 32'd0);
        check("rst_rdata0", rdata0_o[d], 32'd0);
        check("rst_rdata1", rdata1_o[d], 32'd0);
    endtask

    // One isolated access from port p on instance d, checked cycle by cycle.
    task automatic do_access(input int d, input bit p, input bit rw, input logic [3:0] a,
                             input logic [31:0] wd, input bit drop);
        int  k;
        bit  got;
        logic [31:0] exp;
        @(negedge clk);
        set_port(d, p, 1'b1, rw, a, wd);
        @(posedge clk); #1;
        last_gnt[d] = p;
        check("grant_men",  {31'd0, men_o[d]}, 32'd1);
        check("grant_gnt",  {30'd0, gnt1_o[d], gnt0_o[d]}, p ? 32'd2 : 32'd1);
        check("grant_addr", {28'd0, maddr_o[d]}, {28'd0, a});
        check("grant_rw",   {31'd0, mrw_o[d]}, {31'd0, rw});
        if (rw) check("grant_wdata", mwdata_o[d], wd);
        check("grant_busy", {31'd0, busy_o[d]}, 32'd1);
        if (drop) set_port(d, p, 1'b0, ~rw, ~a, ~wd);
        k = 0;
        got = 1'b0;
        while (!got && k < 12) begin
            @(posedge clk); #1;
            k++;
            check("men_once",   {31'd0, men_o[d]}, 32'd0);
            check("addr_stable", {28'd0, maddr_o[d]}, {28'd0, a});
            check("busy_hold",  {31'd0, busy_o[d]}, 32'd1);
            if (p ? ack1_o[d] : ack0_o[d]) begin
                got = 1'b1;
                check("ack_latency", 32'(k), 32'(lat_of(d)));
                exp = rw ? rdata_ref[d][p] : ref_mem[d][a];
                check("rdata", p ? rdata1_o[d] : rdata0_o[d], exp);
                if (rw) ref_mem[d][a] = wd;
                else    rdata_ref[d][p] = ref_mem[d][a];
                set_port(d, p, 1'b0, rw, a, wd);
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        check("end_ack_gnt", {28'd0, ack0_o[d], ack1_o[d], gnt0_o[d], gnt1_o[d]}, 32'd0);
        check("end_busy", {31'd0, busy_o[d]}, 32'd0);
    endtask

    // Both ports hold read requests for n completed accesses.
    task automatic contend(input int d, input int n);
        logic [3:0] a0, a1;
        int acks, grants, cyc;
        bit cur;
        a0 = 4'($urandom);
        a1 = 4'($urandom);
        cur = 1'b0; acks = 0; grants = 0; cyc = 0;
        @(negedge clk);
        set_port(d, 1'b0, 1'b1, RW_READ, a0, 32'd0);
        set_port(d, 1'b1, 1'b1, RW_READ, a1, 32'd0);
        while (acks < n && cyc < 20 * n) begin
            @(posedge clk); #1;
            cyc++;
            if (men_o[d]) begin
                cur = ~last_gnt[d];
                check("rr_order", {31'd0, gnt1_o[d]}, {31'd0, cur});
                last_gnt[d] = cur;
                grants++;
            end
            if (ack0_o[d] || ack1_o[d]) begin
                check("rr_ack_port", {31'd0, ack1_o[d]}, {31'd0, cur});
                check("rr_rdata", cur ? rdata1_o[d] : rdata0_o[d], ref_mem[d][cur ? a1 : a0]);
                rdata_ref[d][cur] = ref_mem[d][cur ? a1 : a0];
                acks++;
                if (acks == n) begin
                    set_port(d, 1'b0, 1'b0, RW_READ, a0, 32'd0);
                    set_port(d, 1'b1, 1'b0, RW_READ, a1, 32'd0);
                end
            end
        end
        check("rr_acks", 32'(acks), 32'(n));
        check("rr_grants", 32'(grants), 32'(n));
        @(posedge clk); #1;
        check("rr_idle", {31'd0, busy_o[d]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        req0   = '0; rw0 = '0; req1 = '0; rw1 = '0;
        addr0  = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++) ref_mem[d][a] = init_word(d, a);

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_reset_outputs(d);
        rst_n = 1'b1;

        // Fairness from reset, then the directed single accesses.
        contend(0, 4);
        contend(1, 4);
        do_access(0, PORT_GPP, RW_READ,  4'h3, 32'd0, 1'b0);
        do_access(0, PORT_LDR, RW_WRITE, 4'hA, 32'h0000_1234, 1'b0);
        do_access(0, PORT_GPP, RW_READ,  4'hA, 32'd0, 1'b0);
        do_access(1, PORT_GPP, RW_READ,  4'hF, 32'd0, 1'b0);
        do_access(0, PORT_GPP, RW_READ,  4'h5, 32'd0, 1'b1);
        do_access(1, PORT_LDR, RW_WRITE, 4'h6, 32'hCAFE_0006, 1'b1);

        // Reset in the middle of a LAT=3 wait abandons the access.
        @(negedge clk);
        set_port(1, PORT_GPP, 1'b1, RW_READ, 4'h7, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(1);
        set_port(1, PORT_GPP, 1'b0, RW_READ, 4'h7, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {29'd0, ack0_o[1], ack1_o[1], busy_o[1]}, 32'd0);
        end

        // Randomised mix of single accesses and contention bursts.
        for (int i = 0; i < 40; i++) begin
            int d;
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                contend(d, int'($urandom_range(2, 4)));
            else
                do_access(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
